// File: rtl/ntr_parallel.sv
// ntr_parallel: deserialiser for the NTR cartridge 8-bit parallel bus.
//   Synchronises the asynchronous bus strobe and data into the clk domain, captures one byte per
//   strobe rising edge and publishes a whole command atomically once BYTES bytes have arrived.
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst_n    in   asynchronous active-low reset
//   ntr_data in   bus data byte, valid around the ntr_clk rising edge
//   ntr_clk  in   bus strobe, asynchronous to clk
//   command  out  last complete command, first byte in [7:0], byte k in [8k+7:8k]
//   ready    out  high while command holds a fresh command (until the next byte is detected)
module ntr_parallel #(
  parameter int unsigned BYTES       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           ntr_data,
  input  logic                 ntr_clk,
  output logic [8*BYTES-1:0]   command,
  output logic                 ready
);

  localparam int unsigned CntW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0]      strobe_sync_q;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q;
  logic                        strobe_prev_q;
  logic [BYTES-1:0][7:0]       buf_q;
  logic [BYTES-1:0][7:0]       buf_full;
  logic [CntW-1:0]             cnt_q;
  logic [ToW-1:0]              to_q;

  logic       strobe_synced;
  logic [7:0] data_synced;
  logic       strobe_rise;
  logic       last_slot;

  assign strobe_synced = strobe_sync_q[SYNC_STAGES-1];
  assign data_synced   = data_sync_q[SYNC_STAGES-1];
  assign strobe_rise   = strobe_synced & ~strobe_prev_q;
  assign last_slot     = (cnt_q == CntW'(BYTES - 1));

  // Buffer as it will look after this byte lands; used to publish the whole command in one edge.
  always_comb begin
    buf_full        = buf_q;
    buf_full[cnt_q] = data_synced;
  end

  // Strobe and data share the same depth so the sampled byte lines up with the detected edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync_q <= '0;
      data_sync_q   <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], ntr_clk};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], ntr_data};
      strobe_prev_q <= strobe_synced;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      command <= '0;
      ready   <= 1'b0;
    end else if (strobe_rise) begin
      // An edge always beats a simultaneous timeout expiry.
      buf_q[cnt_q] <= data_synced;
      to_q         <= '0;
      if (last_slot) begin
        command <= buf_full;
        ready   <= 1'b1;
        cnt_q   <= '0;
      end else begin
        ready <= 1'b0;
        cnt_q <= cnt_q + CntW'(1);
      end
    end else if (cnt_q != '0) begin
      // Partial command stalled: drop it after TIMEOUT idle cycles, leave command/ready alone.
      if (to_q >= ToW'(TIMEOUT - 1)) begin
        cnt_q <= '0;
        to_q  <= '0;
      end else begin
        to_q <= to_q + ToW'(1);
      end
    end else begin
      to_q <= '0;
    end
  end

endmodule

// File: tb/tb_ntr_parallel.sv
module tb_ntr_parallel;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ntr_data;
  logic        ntr_clk;
  logic [63:0] command;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ntr_parallel #(
    .BYTES      (8),
    .SYNC_STAGES(2),
    .TIMEOUT    (1024)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ntr_data(ntr_data),
    .ntr_clk (ntr_clk),
    .command (command),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus byte: low phase with data set up, rising edge, high phase; ph in clk periods.
  task automatic send_byte(input logic [7:0] b, input int ph);
    @(negedge clk);
    ntr_data = b;
    ntr_clk  = 1'b0;
    repeat (ph) @(negedge clk);
    ntr_clk = 1'b1;
    repeat (ph) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    ntr_data = 8'h00;
    ntr_clk  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_command", command, 64'h0);
    check("reset_ready", {63'h0, ready}, 64'h0);
    rst_n = 1'b1;

    // 1: first command with latency check on the 8th byte
    for (int i = 0; i < 7; i++) send_byte(8'(i * 17), 4);
    @(negedge clk);
    ntr_data = 8'h77;
    ntr_clk  = 1'b0;
    repeat (4) @(negedge clk);
    ntr_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("latency_not_early", {63'h0, ready}, 64'h0);
    @(posedge clk);
    #1;
    check("latency_ready", {63'h0, ready}, 64'h1);
    check("cmd1", command, 64'h7766554433221100);
    repeat (3) @(negedge clk);

    // 2: first byte of next command drops ready, command held
    send_byte(8'hAA, 4);
    check("next_byte_ready_low", {63'h0, ready}, 64'h0);
    check("next_byte_cmd_held", command, 64'h7766554433221100);
    for (int i = 1; i < 8; i++) send_byte(8'(i), 4);
    check("cmd2", command, 64'h07060504030201AA);
    check("cmd2_ready", {63'h0, ready}, 64'h1);

    // 3: partial command dropped by timeout
    send_byte(8'hE1, 4);
    send_byte(8'hE2, 4);
    send_byte(8'hE3, 4);
    repeat (1200) @(negedge clk);
    check("timeout_cmd_held", command, 64'h07060504030201AA);
    check("timeout_ready_low", {63'h0, ready}, 64'h0);
    send_byte(8'h9F, 4);
    for (int i = 1; i < 8; i++) send_byte(8'h00, 4);
    check("cmd3_after_timeout", command, 64'h000000000000009F);
    check("cmd3_ready", {63'h0, ready}, 64'h1);

    // 4: reset mid-command discards partial bytes
    for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i), 4);
    @(negedge clk);
    rst_n   = 1'b0;
    ntr_clk = 1'b0;
    @(negedge clk);
    check("midreset_command", command, 64'h0);
    check("midreset_ready", {63'h0, ready}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 4);
    check("cmd4_post_reset", command, 64'h1716151413121110);
    check("cmd4_ready", {63'h0, ready}, 64'h1);

    // 5: data wiggles without a strobe edge are ignored
    ntr_data = 8'h5A;
    repeat (5) @(negedge clk);
    ntr_data = 8'hC3;
    repeat (5) @(negedge clk);
    ntr_clk = 1'b0;
    repeat (5) @(negedge clk);
    ntr_data = 8'h3C;
    repeat (5) @(negedge clk);
    ntr_data = 8'hFF;
    repeat (5) @(negedge clk);
    check("no_edge_cmd", command, 64'h1716151413121110);
    check("no_edge_ready", {63'h0, ready}, 64'h1);

    // 6: minimum phase width, 16 bytes back to back
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 3);
    check("b2b_cmd_a", command, 64'hC7C6C5C4C3C2C1C0);
    check("b2b_ready_a", {63'h0, ready}, 64'h1);
    send_byte(8'hD0, 3);
    check("b2b_ready_drop", {63'h0, ready}, 64'h0);
    check("b2b_cmd_held", command, 64'hC7C6C5C4C3C2C1C0);
    for (int i = 1; i < 8; i++) send_byte(8'hD0 + 8'(i), 3);
    check("b2b_cmd_b", command, 64'hD7D6D5D4D3D2D1D0);
    check("b2b_ready_b", {63'h0, ready}, 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
